// File: rtl/xcorr_lags_pkg.sv
// Shared definitions for the multi-lag correlator.
//   - Q-format widths: Q15 samples and Q30 products
//   - default accumulator width
//   - controller state encoding
//   - saturation bounds at the default accumulator width; narrower
//     accumulators derive their bounds by arithmetic right shift
// Optional build macro used by this block: XCORR_SATURATE_EN
package xcorr_lags_pkg;

   localparam int Q15_DIM_IN  = 16;
   localparam int Q30_MUL_OUT = 2 * Q15_DIM_IN;
   localparam int ACC_DIM_ADD = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic signed [63:0] SAT_MAX_64 = 64'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [63:0] SAT_MIN_64 = 64'sh8000_0000_0000_0000;

endpackage

// File: rtl/xcorr_lags_if.sv
// Sample / control / readout bundle of the correlator.
//   slave  : correlator side (takes start, n_samples, en, x, y, rd_lag;
//            returns busy, done, ovf and the three bank read values)
//   master : front-end / bus side
interface xcorr_lags_if #(
   parameter int DIM_IN        = 16,
   parameter int DIM_ADD       = 64,
   parameter int LOG2_NLAGS    = 3,
   parameter int LOG2_NSAMPLES = 33
);
   logic                        start;
   logic [LOG2_NSAMPLES-1:0]    n_samples;
   logic                        en;
   logic signed [DIM_IN-1:0]    x;
   logic signed [DIM_IN-1:0]    y;
   logic                        busy;
   logic                        done;
   logic                        ovf;
   logic [LOG2_NLAGS-1:0]       rd_lag;
   logic signed [DIM_ADD-1:0]   sum_x2;
   logic signed [DIM_ADD-1:0]   sum_y2;
   logic signed [DIM_ADD-1:0]   sum_xy;

   modport slave (
      input  start, n_samples, en, x, y, rd_lag,
      output busy, done, ovf, sum_x2, sum_y2, sum_xy
   );

   modport master (
      output start, n_samples, en, x, y, rd_lag,
      input  busy, done, ovf, sum_x2, sum_y2, sum_xy
   );
endinterface

// File: rtl/xcorr_lags_mac_clr.sv
// Registered-product multiply-accumulate with synchronous clear.
//   clk, clr_n : clock, async active-low reset
//   clr        : synchronous zero of product, accumulator and ovf flag
//   en         : accept a*b this cycle (product registered, added next cycle)
//   a, b       : signed operands
//   acc, ovf   : running sum and sticky signed-overflow flag
// XCORR_SATURATE_EN: clamp on first overflow and hold the clamp value;
// otherwise the sum wraps two's complement.
module xcorr_lags_mac_clr
   import xcorr_lags_pkg::*;
#(
   parameter int DIM_IN  = Q15_DIM_IN,
   parameter int MUL_OUT = 2 * DIM_IN,
   parameter int DIM_ADD = ACC_DIM_ADD
) (
   input  logic                      clk,
   input  logic                      clr_n,
   input  logic                      clr,
   input  logic                      en,
   input  logic signed [DIM_IN-1:0]  a,
   input  logic signed [DIM_IN-1:0]  b,
   output logic signed [DIM_ADD-1:0] acc,
   output logic                      ovf
);

`ifdef XCORR_SATURATE_EN
   // bounds at DIM_ADD width (DIM_ADD <= 64)
   localparam logic signed [63:0] MAX_SH = SAT_MAX_64 >>> (64 - DIM_ADD);
   localparam logic signed [63:0] MIN_SH = SAT_MIN_64 >>> (64 - DIM_ADD);
   localparam logic signed [DIM_ADD-1:0] ACC_MAX = MAX_SH[DIM_ADD-1:0];
   localparam logic signed [DIM_ADD-1:0] ACC_MIN = MIN_SH[DIM_ADD-1:0];
`endif

   logic signed [MUL_OUT-1:0] prod_q, prod_d;
   logic signed [MUL_OUT-1:0] a_ext, b_ext;
   logic                      vld_q, vld_d;
   logic signed [DIM_ADD-1:0] acc_q, acc_d;
   logic signed [DIM_ADD-1:0] prod_ext, sum;
   logic                      ovf_q, ovf_d;
   logic                      wrap;

   always_comb begin
      a_ext    = {{(MUL_OUT-DIM_IN){a[DIM_IN-1]}}, a};
      b_ext    = {{(MUL_OUT-DIM_IN){b[DIM_IN-1]}}, b};
      prod_ext = {{(DIM_ADD-MUL_OUT){prod_q[MUL_OUT-1]}}, prod_q};
      sum      = acc_q + prod_ext;
      // same-sign operands producing an opposite-sign result
      wrap     = (acc_q[DIM_ADD-1] == prod_ext[DIM_ADD-1]) &&
                 (sum[DIM_ADD-1] != acc_q[DIM_ADD-1]);

      prod_d = prod_q;
      vld_d  = en;
      acc_d  = acc_q;
      ovf_d  = ovf_q;

      if (en) begin
         prod_d = a_ext * b_ext;
      end

      if (vld_q) begin
`ifdef XCORR_SATURATE_EN
         // once clamped the accumulator is frozen for the rest of the window
         if (!ovf_q) begin
            acc_d = wrap ? (prod_ext[DIM_ADD-1] ? ACC_MIN : ACC_MAX) : sum;
            ovf_d = wrap;
         end
`else
         acc_d = sum;
         ovf_d = ovf_q | wrap;
`endif
      end

      if (clr) begin
         prod_d = '0;
         vld_d  = 1'b0;
         acc_d  = '0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         prod_q <= '0;
         vld_q  <= 1'b0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         prod_q <= prod_d;
         vld_q  <= vld_d;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/xcorr_lags.sv
// Multi-lag correlator: over a window of n_samples accepted samples it
// accumulates sum x^2, sum y^2 and sum x[n]*y[n-k] for k = 0..NLAGS-1,
// then snapshots everything into a result bank read by lag index.
//   clk, clr_n : clock, async active-low reset
//   bus        : xcorr_lags_if.slave (start/n_samples/en/x/y in,
//                busy/done/ovf out, rd_lag in, sum_x2/sum_y2/sum_xy out)
// Optional build macro: XCORR_SATURATE_EN (accumulators clamp instead of wrap).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; bank holds last window's results
// ST_ACC   | accepting samples while en=1, counting down n_samples
// ST_DRAIN | two cycles for the product/accumulate pipeline to empty
// ST_DONE  | copy accumulators into bank, raise done on leaving
module xcorr_lags
   import xcorr_lags_pkg::*;
#(
   parameter int DIM_IN        = Q15_DIM_IN,
   parameter int MUL_OUT       = 2 * DIM_IN,
   parameter int DIM_ADD       = ACC_DIM_ADD,
   parameter int NLAGS         = 8,
   parameter int LOG2_NLAGS    = 3,
   parameter int LOG2_NSAMPLES = 33
) (
   input  logic        clk,
   input  logic        clr_n,
   xcorr_lags_if.slave bus
);

   localparam int NDL = (NLAGS > 1) ? NLAGS - 1 : 1;

   state_t                     state_q, state_d;
   logic [LOG2_NSAMPLES-1:0]   cnt_q, cnt_d;
   logic                       drain_q, drain_d;
   logic                       done_q, done_d;
   logic signed [DIM_IN-1:0]   ydl_q [NDL];
   logic signed [DIM_IN-1:0]   ydl_d [NDL];
   logic signed [DIM_IN-1:0]   yd    [NLAGS];

   logic signed [DIM_ADD-1:0]  bank_x2_q, bank_x2_d;
   logic signed [DIM_ADD-1:0]  bank_y2_q, bank_y2_d;
   logic signed [DIM_ADD-1:0]  bank_xy_q [NLAGS];
   logic signed [DIM_ADD-1:0]  bank_xy_d [NLAGS];
   logic                       bank_ovf_q, bank_ovf_d;

   logic signed [DIM_ADD-1:0]  acc_x2, acc_y2;
   logic signed [DIM_ADD-1:0]  acc_xy [NLAGS];
   logic                       ovf_x2, ovf_y2;
   logic [NLAGS-1:0]           ovf_xy;

   logic                       acc_clr, acc_en;

   assign acc_clr = (state_q == ST_IDLE) && bus.start;
   assign acc_en  = (state_q == ST_ACC) && bus.en;

   // yd[k] is y delayed by k accepted samples; yd[0] is the live input
   always_comb begin
      yd[0] = bus.y;
      for (int k = 1; k < NLAGS; k++) begin
         yd[k] = ydl_q[k-1];
      end
   end

   xcorr_lags_mac_clr #(.DIM_IN(DIM_IN), .MUL_OUT(MUL_OUT), .DIM_ADD(DIM_ADD)) u_mac_x2 (
      .clk(clk), .clr_n(clr_n), .clr(acc_clr), .en(acc_en),
      .a(bus.x), .b(bus.x), .acc(acc_x2), .ovf(ovf_x2)
   );

   xcorr_lags_mac_clr #(.DIM_IN(DIM_IN), .MUL_OUT(MUL_OUT), .DIM_ADD(DIM_ADD)) u_mac_y2 (
      .clk(clk), .clr_n(clr_n), .clr(acc_clr), .en(acc_en),
      .a(bus.y), .b(bus.y), .acc(acc_y2), .ovf(ovf_y2)
   );

   for (genvar g = 0; g < NLAGS; g++) begin : g_lag
      xcorr_lags_mac_clr #(.DIM_IN(DIM_IN), .MUL_OUT(MUL_OUT), .DIM_ADD(DIM_ADD)) u_mac_xy (
         .clk(clk), .clr_n(clr_n), .clr(acc_clr), .en(acc_en),
         .a(bus.x), .b(yd[g]), .acc(acc_xy[g]), .ovf(ovf_xy[g])
      );
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      done_d     = 1'b0;
      ydl_d      = ydl_q;
      bank_x2_d  = bank_x2_q;
      bank_y2_d  = bank_y2_q;
      bank_xy_d  = bank_xy_q;
      bank_ovf_d = bank_ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               cnt_d   = bus.n_samples;
               drain_d = 1'b0;
               for (int k = 0; k < NDL; k++) begin
                  ydl_d[k] = '0;
               end
               state_d = (bus.n_samples == '0) ? ST_DRAIN : ST_ACC;
            end
         end
         ST_ACC: begin
            if (bus.en) begin
               cnt_d    = cnt_q - 1'b1;
               ydl_d[0] = bus.y;
               for (int k = 1; k < NDL; k++) begin
                  ydl_d[k] = ydl_q[k-1];
               end
               if (cnt_q == LOG2_NSAMPLES'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            drain_d = ~drain_q;
            if (drain_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bank_x2_d  = acc_x2;
            bank_y2_d  = acc_y2;
            bank_xy_d  = acc_xy;
            bank_ovf_d = ovf_x2 | ovf_y2 | (|ovf_xy);
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         drain_q    <= 1'b0;
         done_q     <= 1'b0;
         bank_x2_q  <= '0;
         bank_y2_q  <= '0;
         bank_ovf_q <= 1'b0;
         for (int k = 0; k < NDL; k++) begin
            ydl_q[k] <= '0;
         end
         for (int k = 0; k < NLAGS; k++) begin
            bank_xy_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drain_q    <= drain_d;
         done_q     <= done_d;
         ydl_q      <= ydl_d;
         bank_x2_q  <= bank_x2_d;
         bank_y2_q  <= bank_y2_d;
         bank_xy_q  <= bank_xy_d;
         bank_ovf_q <= bank_ovf_d;
      end
   end

   assign bus.busy   = (state_q == ST_ACC) || (state_q == ST_DRAIN);
   assign bus.done   = done_q;
   assign bus.ovf    = bank_ovf_q;
   assign bus.sum_x2 = bank_x2_q;
   assign bus.sum_y2 = bank_y2_q;

   // out-of-range lag indices read as zero
   always_comb begin
      bus.sum_xy = '0;
      for (int k = 0; k < NLAGS; k++) begin
         if (bus.rd_lag == LOG2_NLAGS'(k)) begin
            bus.sum_xy = bank_xy_q[k];
         end
      end
   end

endmodule

// File: tb/tb_xcorr_lags.sv
module tb_xcorr_lags;

   localparam int W  = 40;
   localparam int NL = 8;

   typedef struct packed {
      logic                   ovf;
      logic [W-1:0]           x2;
      logic [W-1:0]           y2;
      logic [NL-1:0][W-1:0]   xy;
   } exp_t;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   xcorr_lags_if #(.DIM_IN(16), .DIM_ADD(W), .LOG2_NLAGS(4), .LOG2_NSAMPLES(33)) bus ();

   xcorr_lags #(
      .DIM_IN(16), .MUL_OUT(32), .DIM_ADD(W), .NLAGS(NL),
      .LOG2_NLAGS(4), .LOG2_NSAMPLES(33)
   ) dut (
      .clk(clk), .clr_n(clr_n), .bus(bus)
   );

   logic signed [15:0] xs_a [0:1023];
   logic signed [15:0] ys_a [0:1023];
   bit                 pat  [7] = '{1, 0, 0, 1, 1, 0, 1};
   exp_t               sb_q [$];
   int                 ntot = 0;
   int                 nbad = 0;
   int                 last_cyc = 0;
   logic [W-1:0]       prev_x2 = '0;

   // Exact sum in 64 bits, then folded into W bits: wrap keeps the low bits,
   // saturation freezes at the bound first crossed. Overflow is flagged when
   // any prefix sum leaves the signed W-bit range.
   function automatic logic [W:0] model_acc(input int kind, input int lag, input int n);
      longint acc = 0;
      longint t;
      longint maxv = (longint'(1) <<< (W - 1)) - 1;
      longint minv = -(longint'(1) <<< (W - 1));
      bit     oob = 1'b0;
      longint clampv = 0;
      logic [W-1:0] val;
      for (int i = 0; i < n; i++) begin
         if (kind == 0)      t = longint'(xs_a[i]) * longint'(xs_a[i]);
         else if (kind == 1) t = longint'(ys_a[i]) * longint'(ys_a[i]);
         else if (i >= lag)  t = longint'(xs_a[i]) * longint'(ys_a[i-lag]);
         else                t = 0;
         acc += t;
         if (!oob && (acc > maxv || acc < minv)) begin
            oob = 1'b1;
            clampv = (acc > maxv) ? maxv : minv;
         end
      end
`ifdef XCORR_SATURATE_EN
      val = oob ? clampv[W-1:0] : acc[W-1:0];
`else
      val = acc[W-1:0];
`endif
      return {oob, val};
   endfunction

   task automatic push_expected(input int n);
      exp_t e;
      logic [W:0] r;
      r = model_acc(0, 0, n); e.x2 = r[W-1:0]; e.ovf = r[W];
      r = model_acc(1, 0, n); e.y2 = r[W-1:0]; e.ovf = e.ovf | r[W];
      for (int k = 0; k < NL; k++) begin
         r = model_acc(2, k, n);
         e.xy[k] = r[W-1:0];
         e.ovf = e.ovf | r[W];
      end
      sb_q.push_back(e);
   endtask

   // pat_mode=1 uses the stall pattern; skipped cycles carry junk data.
   task automatic drive_window(input int n, input bit pat_mode, input bit mid_start, input bit chk_prev);
      int i = 0;
      int p = 0;
      bit e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.n_samples = 33'(n);
      push_expected(n);
      @(negedge clk);
      bus.start = 1'b0;
      last_cyc = cyc;
      while (i < n && p < 5000) begin
         e = pat_mode ? pat[p % 7] : 1'b1;
         p++;
         bus.en = e;
         bus.x  = e ? xs_a[i] : 16'sh7777;
         bus.y  = e ? ys_a[i] : -16'sh1234;
         if (mid_start && i == 1) begin
            bus.start = 1'b1;
            bus.n_samples = 33'd2;
         end
         @(negedge clk);
         bus.start = 1'b0;
         if (chk_prev) begin
            ntot++;
            if (bus.sum_x2 !== prev_x2 || bus.busy !== 1'b1) begin
               nbad++;
               $display("FAIL bank_hold: sum_x2=%h busy=%b expected sum_x2=%h busy=1", bus.sum_x2, bus.busy, prev_x2);
            end
         end
         if (e) begin
            i++;
            last_cyc = cyc;
         end
      end
      bus.en = 1'b0;
      bus.x  = '0;
      bus.y  = '0;
   endtask

   task automatic collect(input string name);
      exp_t e;
      int t = 0;
      while (!bus.done && t < 20) begin
         @(negedge clk);
         t++;
      end
      e = sb_q.pop_front();
      ntot++;
      if (bus.done !== 1'b1) begin
         nbad++;
         $display("FAIL %s_done_timeout: done=%b after %0d cycles, expected 1", name, bus.done, t);
      end else if (cyc - last_cyc != 3) begin
         nbad++;
         $display("FAIL %s_latency: got %0d cycles expected 3", name, cyc - last_cyc);
      end
      ntot++;
      if (bus.sum_x2 !== e.x2 || bus.sum_y2 !== e.y2 || bus.ovf !== e.ovf) begin
         nbad++;
         $display("FAIL %s_sq: x2=%h y2=%h ovf=%b expected x2=%h y2=%h ovf=%b",
                  name, bus.sum_x2, bus.sum_y2, bus.ovf, e.x2, e.y2, e.ovf);
      end
      for (int k = 0; k < NL; k++) begin
         bus.rd_lag = 4'(k);
         #1;
         ntot++;
         if (bus.sum_xy !== e.xy[k]) begin
            nbad++;
            $display("FAIL %s_xy%0d: got %h expected %h", name, k, bus.sum_xy, e.xy[k]);
         end
      end
      bus.rd_lag = '0;
      prev_x2 = e.x2;
      @(negedge clk);
      ntot++;
      if (bus.done !== 1'b0) begin
         nbad++;
         $display("FAIL %s_done_pulse: done=%b one cycle later, expected 0", name, bus.done);
      end
   endtask

   task automatic load_const(input logic signed [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         xs_a[i] = v;
         ys_a[i] = v;
      end
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 16; i++) begin
         xs_a[i] = 16'(i + 1);
         ys_a[i] = 16'(10 * (i + 1));
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      bus.start = 1'b0; bus.n_samples = '0; bus.en = 1'b0;
      bus.x = '0; bus.y = '0; bus.rd_lag = '0;
      repeat (3) @(negedge clk);
      ntot++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
          bus.sum_x2 !== '0 || bus.sum_y2 !== '0 || bus.sum_xy !== '0) begin
         nbad++;
         $display("FAIL reset: busy=%b done=%b ovf=%b x2=%h y2=%h xy=%h expected all 0",
                  bus.busy, bus.done, bus.ovf, bus.sum_x2, bus.sum_y2, bus.sum_xy);
      end
      clr_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      load_const(16'sh4000, 4);
      drive_window(4, 1'b0, 1'b0, 1'b0);
      collect("basic");
   endtask

   task automatic test_stall();
      load_const(16'sh4000, 4);
      drive_window(4, 1'b1, 1'b0, 1'b0);
      collect("stall");
   endtask

   task automatic test_lag_align();
      load_ramp();
      drive_window(4, 1'b0, 1'b0, 1'b0);
      collect("lag");
      bus.rd_lag = 4'd9;
      #1;
      ntot++;
      if (bus.sum_xy !== '0) begin
         nbad++;
         $display("FAIL lag_oob: rd_lag=9 got %h expected 0", bus.sum_xy);
      end
      bus.rd_lag = '0;
   endtask

   task automatic test_start_ignored();
      load_const(16'sh4000, 4);
      drive_window(4, 1'b0, 1'b1, 1'b1);
      collect("start_ign");
   endtask

   task automatic test_zero_len();
      drive_window(0, 1'b0, 1'b0, 1'b0);
      collect("zero_len");
   endtask

   task automatic test_overflow();
      load_const(-16'sh8000, 600);
      drive_window(600, 1'b0, 1'b0, 1'b0);
      collect("overflow");
   endtask

   task automatic test_reset_mid();
      bit saw_done = 1'b0;
      load_ramp();
      @(negedge clk);
      bus.start = 1'b1;
      bus.n_samples = 33'd10;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.en = 1'b1; bus.x = xs_a[i]; bus.y = ys_a[i];
         @(negedge clk);
      end
      clr_n = 1'b0;
      bus.en = 1'b0;
      #1;
      ntot++;
      if (bus.busy !== 1'b0 || bus.sum_x2 !== '0 || bus.ovf !== 1'b0) begin
         nbad++;
         $display("FAIL reset_mid: busy=%b x2=%h ovf=%b expected 0 0 0", bus.busy, bus.sum_x2, bus.ovf);
      end
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      ntot++;
      if (saw_done !== 1'b0) begin
         nbad++;
         $display("FAIL reset_mid_done: done pulsed=%b expected 0", saw_done);
      end
      drive_window(4, 1'b0, 1'b0, 1'b0);
      collect("post_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_lag_align();
      test_start_ignored();
      test_zero_len();
      test_overflow();
      test_reset_mid();
      ntot++;
      if (sb_q.size() != 0) begin
         nbad++;
         $display("FAIL scoreboard_left: %0d entries expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
